// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encodings, parameter defaults, bus widths and the latched bus-field bundle.
package mem_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;
   localparam int CNT_W  = 8;

   localparam int DEF_TIMEOUT      = 16;
   localparam int DEF_STARVE_LIMIT = 3;

   localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IF_BUSY  = 2'd1,
      ST_MEM_BUSY = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_fields_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (fetch and load/store)
// and the shared memory port. The arbiter uses the slave modport; the
// requesters and the memory together form the master side.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_ack_o;
   logic              if_err_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_stall_o;

   logic              mem_req_i;
   logic              mem_we_i;
   logic [SEL_W-1:0]  mem_sel_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [DATA_W-1:0] mem_wdata_i;
   logic              mem_ack_o;
   logic              mem_err_o;
   logic [DATA_W-1:0] mem_rdata_o;
   logic              mem_stall_o;

   logic              bus_ce_o;
   logic              bus_we_o;
   logic [SEL_W-1:0]  bus_sel_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic [DATA_W-1:0] bus_wdata_o;
   logic [DATA_W-1:0] bus_rdata_i;
   logic              bus_ack_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_ack_o, if_err_o, if_rdata_o, if_stall_o,
      input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
      output mem_ack_o, mem_err_o, mem_rdata_o, mem_stall_o,
      output bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
      input  bus_rdata_i, bus_ack_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_ack_o, if_err_o, if_rdata_o, if_stall_o,
      output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
      input  mem_ack_o, mem_err_o, mem_rdata_o, mem_stall_o,
      input  bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
      output bus_rdata_i, bus_ack_i
   );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// Bus-transaction watchdog for the memory arbiter. Counts busy cycles that
// ended without an acknowledge; terminal is high in the cycle where the
// count reaches TIMEOUT-1, which is the last cycle the arbiter will wait.
module mem_arb_timeout
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [CNT_W-1:0] count;

   // Wait counter: restarts whenever the arbiter is idle, advances on every unacknowledged busy cycle
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !terminal) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single shared memory port. Fetch (IF) and
// load/store (MEM) requests are serialised onto one registered bus; MEM has
// strict priority, and a stalled bus is abandoned with an error after TIMEOUT
// cycles. Defining MEM_ARB_FAIR_EN adds a starvation counter that hands the
// bus to IF after STARVE_LIMIT consecutive MEM wins over a waiting fetch.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT      = DEF_TIMEOUT,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave arb
);

   arb_state_t  state;
   arb_state_t  state_next;
   bus_fields_t bus_q;
   logic        bus_ce_q;

   logic grant_if;
   logic grant_mem;
   logic force_if;
   logic busy;
   logic to_terminal;
   logic done;
   logic timed_out;

   assign busy      = (state != ST_IDLE);
   assign done      = busy && (arb.bus_ack_i || to_terminal);
   assign timed_out = busy && !arb.bus_ack_i && to_terminal;

   mem_arb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear    (state == ST_IDLE),
      .enable   (busy && !arb.bus_ack_i),
      .terminal (to_terminal)
   );

`ifdef MEM_ARB_FAIR_EN
   logic [CNT_W-1:0] starve_cnt;

   // Starvation tracking: count MEM wins while a fetch waits, forget them once IF is served or stops asking
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if ((state == ST_IDLE) && !arb.if_req_i) begin
         starve_cnt <= '0;
      end else if (grant_mem && arb.if_req_i && (starve_cnt != '1)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign force_if = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
   logic [CNT_W-1:0] unused_starve_limit;

   assign unused_starve_limit = CNT_W'(STARVE_LIMIT);
   assign force_if            = 1'b0;
`endif

   // Arbitration: only decided in IDLE; MEM first unless a starved fetch is being forced through
   always_comb begin
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      if (state == ST_IDLE) begin
         if (arb.mem_req_i && !(arb.if_req_i && force_if)) begin
            grant_mem = 1'b1;
         end else if (arb.if_req_i) begin
            grant_if = 1'b1;
         end
      end
   end

   // Next-state logic: enter the winner's busy state, return to IDLE on ack or timeout
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (grant_mem) begin
               state_next = ST_MEM_BUSY;
            end else if (grant_if) begin
               state_next = ST_IF_BUSY;
            end
         end
         ST_IF_BUSY, ST_MEM_BUSY: begin
            if (done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and bus registers: fields are captured at the grant edge and frozen until the transaction ends
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         bus_ce_q <= 1'b0;
         bus_q    <= '0;
      end else begin
         state    <= state_next;
         bus_ce_q <= (state_next != ST_IDLE);
         if (grant_mem) begin
            bus_q.we    <= arb.mem_we_i;
            bus_q.sel   <= arb.mem_sel_i;
            bus_q.addr  <= arb.mem_addr_i;
            bus_q.wdata <= arb.mem_wdata_i;
         end else if (grant_if) begin
            bus_q.we    <= 1'b0;
            bus_q.sel   <= SEL_ALL;
            bus_q.addr  <= arb.if_addr_i;
            bus_q.wdata <= '0;
         end else if (done) begin
            bus_q <= '0;
         end
      end
   end

   assign arb.bus_ce_o    = bus_ce_q;
   assign arb.bus_we_o    = bus_q.we;
   assign arb.bus_sel_o   = bus_q.sel;
   assign arb.bus_addr_o  = bus_q.addr;
   assign arb.bus_wdata_o = bus_q.wdata;

   // Completion signalling: only the bus owner sees ack/err, and read data passes through only on a real ack
   always_comb begin
      arb.if_ack_o    = 1'b0;
      arb.if_err_o    = 1'b0;
      arb.if_rdata_o  = '0;
      arb.mem_ack_o   = 1'b0;
      arb.mem_err_o   = 1'b0;
      arb.mem_rdata_o = '0;
      if (state == ST_IF_BUSY) begin
         arb.if_ack_o = done;
         arb.if_err_o = timed_out;
         if (arb.bus_ack_i) begin
            arb.if_rdata_o = arb.bus_rdata_i;
         end
      end else if (state == ST_MEM_BUSY) begin
         arb.mem_ack_o = done;
         arb.mem_err_o = timed_out;
         if (arb.bus_ack_i) begin
            arb.mem_rdata_o = arb.bus_rdata_i;
         end
      end
   end

   assign arb.if_stall_o  = arb.if_req_i && !arb.if_ack_o;
   assign arb.mem_stall_o = arb.mem_req_i && !arb.mem_ack_o;

endmodule
